// File: rtl/wlo_search_ctrl.sv
// Greedy word-length search: per variable, trims fractional bits one at a time while the
// externally evaluated error stays within threshold, restoring the last good value on reject.
module wlo_search_ctrl #(
    parameter int NUM_VAR  = 4,
    parameter int MAX_LEN  = 32,
    parameter int INT_POS  = 16,
    parameter int MIN_FRAC = 0,
    parameter int ERR_W    = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [7:0]             init_int,
    input  logic [7:0]             init_frac,
    input  logic [ERR_W-1:0]       err_thresh,
    output logic                   eval_start,
    input  logic                   eval_done,
    input  logic [ERR_W-1:0]       eval_err,
    output logic [NUM_VAR*8-1:0]   cfg_int,
    output logic [NUM_VAR*8-1:0]   cfg_frac,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            iter_cnt,
    output logic                   timeout_flag
);

    localparam int VW = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [7:0]    INT_POS8  = 8'(INT_POS);
    localparam logic [7:0]    MIN_FRAC8 = 8'(MIN_FRAC);
    localparam logic [7:0]    RST_INT8  = 8'(MAX_LEN - INT_POS);
    localparam logic [VW-1:0] LAST_V    = VW'(NUM_VAR - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, INIT, TRY, EVAL, DECIDE, NEXT, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        int_q  [NUM_VAR];
    logic [7:0]        frac_q [NUM_VAR];
    logic [VW-1:0]     v;
    logic [TW-1:0]     timer;
    logic [ERR_W-1:0]  thresh_q;
    logic [ERR_W-1:0]  err_q;
    logic              trial_tmo;

    logic at_min;
    logic got_done;
    logic expired;
    logic accept;
    logic aborting;

    // The evaluator cannot answer in the same cycle it is started, so the first EVAL cycle ignores eval_done.
    assign at_min   = frac_q[v] <= MIN_FRAC8;
    assign got_done = eval_done && (timer != '0);
    assign expired  = !got_done && (timer == TMO_LAST);
    assign accept   = !trial_tmo && (err_q <= thresh_q);
    assign aborting = abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = TRY;
            TRY:     state_nxt = at_min ? NEXT : EVAL;
            EVAL:    if (got_done || expired) state_nxt = DECIDE;
            DECIDE:  state_nxt = accept ? TRY : NEXT;
            NEXT:    state_nxt = (v == LAST_V) ? DONE : TRY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (aborting) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VAR; i++) begin
                int_q[i]  <= RST_INT8;
                frac_q[i] <= INT_POS8;
            end
            v            <= '0;
            timer        <= '0;
            thresh_q     <= '0;
            err_q        <= '0;
            trial_tmo    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            eval_start   <= 1'b0;
            iter_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            busy       <= state_nxt != IDLE;
            done       <= state_nxt == DONE;
            eval_start <= (state == TRY) && (state_nxt == EVAL);
            if (aborting) begin
                // A trial in flight holds a decremented value that was never accepted.
                if (state == EVAL || state == DECIDE) frac_q[v] <= frac_q[v] + 8'd1;
            end else begin
                case (state)
                    INIT: begin
                        for (int i = 0; i < NUM_VAR; i++) begin
                            int_q[i]  <= init_int;
                            frac_q[i] <= (init_frac > INT_POS8) ? INT_POS8 : init_frac;
                        end
                        v            <= '0;
                        iter_cnt     <= '0;
                        timeout_flag <= 1'b0;
                        thresh_q     <= err_thresh;
                    end
                    TRY: begin
                        if (!at_min) frac_q[v] <= frac_q[v] - 8'd1;
                        timer     <= '0;
                        trial_tmo <= 1'b0;
                    end
                    EVAL: begin
                        timer <= timer + TW'(1);
                        if (got_done) begin
                            err_q <= eval_err;
                        end else if (expired) begin
                            trial_tmo    <= 1'b1;
                            timeout_flag <= 1'b1;
                        end
                    end
                    DECIDE: begin
                        if (iter_cnt != 16'hFFFF) iter_cnt <= iter_cnt + 16'd1;
                        if (!accept) frac_q[v] <= frac_q[v] + 8'd1;
                    end
                    NEXT: if (v != LAST_V) v <= v + VW'(1);
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_VAR; g++) begin : g_pack
        assign cfg_int[8*g +: 8]  = int_q[g];
        assign cfg_frac[8*g +: 8] = frac_q[g];
    end

endmodule

// File: tb/tb_wlo_search_ctrl.sv
// Bench for wlo_search_ctrl: a transaction-level greedy-search model predicts every trial
// configuration and the final result; an evaluator stand-in answers eval_start requests.
module tb_wlo_search_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  init_int;
    logic [7:0]  init_frac;
    logic [31:0] err_thresh;
    logic        eval_start;
    logic        eval_done;
    logic [31:0] eval_err;
    logic [15:0] cfg_int;
    logic [15:0] cfg_frac;
    logic        busy;
    logic        done;
    logic [15:0] iter_cnt;
    logic        timeout_flag;

    wlo_search_ctrl #(
        .NUM_VAR(2), .MAX_LEN(32), .INT_POS(16), .MIN_FRAC(2), .ERR_W(32), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .init_int(init_int), .init_frac(init_frac), .err_thresh(err_thresh),
        .eval_start(eval_start), .eval_done(eval_done), .eval_err(eval_err),
        .cfg_int(cfg_int), .cfg_frac(cfg_frac), .busy(busy), .done(done),
        .iter_cnt(iter_cnt), .timeout_flag(timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Evaluator behaviour: error is a sum of per-lane table entries; silent lanes never answer.
    int unsigned tab0 [0:16];
    int unsigned tab1 [0:16];
    bit          sil0 [0:16];
    bit          sil1 [0:16];
    int          lat_fix = 0;
    int          late_req = 0;

    function automatic logic [31:0] err_of(input logic [15:0] c);
        return tab0[c[7:0]] + tab1[c[15:8]];
    endfunction

    function automatic bit is_silent(input logic [15:0] c);
        return sil0[c[7:0]] | sil1[c[15:8]];
    endfunction

    task automatic set_tabs(input int emode, input int smode);
        for (int i = 0; i <= 16; i++) begin
            case (emode)
                0:       begin tab0[i] = 0; tab1[i] = 0; end
                1:       begin tab0[i] = (i >= 4) ? 50 : 51; tab1[i] = (i >= 4) ? 50 : 51; end
                default: begin tab0[i] = $urandom_range(50, 0); tab1[i] = $urandom_range(50, 0); end
            endcase
            case (smode)
                0:       begin sil0[i] = 1'b0; sil1[i] = 1'b0; end
                1:       begin sil0[i] = 1'b1; sil1[i] = 1'b1; end
                default: begin sil0[i] = ($urandom_range(15, 0) == 0); sil1[i] = ($urandom_range(15, 0) == 0); end
            endcase
        end
    endtask

    initial begin
        int rcnt;
        int late_seen;
        logic [31:0] rerr;
        rcnt = 0; late_seen = 0; rerr = '0;
        eval_done = 1'b0;
        eval_err  = '0;
        forever begin
            @(negedge clk);
            eval_done = 1'b0;
            if (late_seen != late_req) begin
                late_seen = late_req;
                rcnt = 3;
                rerr = '0;
            end
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    eval_done = 1'b1;
                    eval_err  = rerr;
                end
            end
            if (eval_start === 1'b1) begin
                if (is_silent(cfg_frac)) rcnt = 0;
                else begin
                    rcnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(5, 1));
                    rerr = err_of(cfg_frac);
                end
            end
        end
    end

    // Reference: greedy descent per variable, MIN_FRAC = 2, init clamped to 16.
    logic [15:0] exp_q [$];
    logic [15:0] exp_frac;
    logic [15:0] exp_int;
    int          exp_iter;
    bit          exp_tmo;

    task automatic model(input logic [7:0] fi, input logic [31:0] th);
        int f [2];
        logic [15:0] c;
        bit go;
        f[0] = (fi > 16) ? 16 : int'(fi);
        f[1] = f[0];
        exp_q.delete();
        exp_iter = 0;
        exp_tmo  = 1'b0;
        for (int vv = 0; vv < 2; vv++) begin
            go = 1'b1;
            while (go && f[vv] > 2) begin
                f[vv]--;
                c = {8'(f[1]), 8'(f[0])};
                exp_q.push_back(c);
                exp_iter++;
                if (is_silent(c)) begin exp_tmo = 1'b1; f[vv]++; go = 1'b0; end
                else if (err_of(c) > th) begin f[vv]++; go = 1'b0; end
            end
        end
        exp_frac = {8'(f[1]), 8'(f[0])};
    endtask

    bit mon_en   = 1'b0;
    int es_cnt   = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (eval_start === 1'b1) es_cnt++;
        if (done === 1'b1) done_cnt++;
        if (mon_en) begin
            if (eval_start === 1'b1) begin
                chk("trial_avail", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("trial_cfg", cfg_frac, exp_q.pop_front());
                chk("trial_int", cfg_int, exp_int);
            end
            if (done === 1'b1) begin
                chk("done_cfg", cfg_frac, exp_frac);
                chk("done_iter", iter_cnt, 32'(exp_iter));
            end
        end else if (rst === 1'b0) begin
            chk("quiet", {eval_start, done}, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_search(input logic [7:0] ii, input logic [7:0] fi, input logic [31:0] th,
                              input int extra_start);
        int d0, e0, cyc;
        model(fi, th);
        exp_int    = {ii, ii};
        init_int   = ii;
        init_frac  = fi;
        err_thresh = th;
        d0 = done_cnt;
        e0 = es_cnt;
        mon_en = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", busy, 1);
        cyc = 0;
        while (busy && cyc < 4000) begin
            tick();
            cyc++;
            start = (extra_start != 0) && (cyc == extra_start) && busy;
        end
        start = 1'b0;
        chk("search_end", busy, 0);
        chk("done_pulses", 32'(done_cnt - d0), 1);
        chk("eval_pulses", 32'(es_cnt - e0), 32'(exp_iter));
        chk("final_frac", cfg_frac, exp_frac);
        chk("final_int", cfg_int, exp_int);
        chk("final_iter", iter_cnt, 32'(exp_iter));
        chk("final_tmo", timeout_flag, 32'(exp_tmo));
        chk("trials_left", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        tick();
    endtask

    initial begin
        int d0, cyc;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        init_int = '0; init_frac = '0; err_thresh = '0;
        set_tabs(0, 0);

        repeat (2) tick();
        chk("rst_cfg_int", cfg_int, 16'h1010);
        chk("rst_cfg_frac", cfg_frac, 16'h1010);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_eval_start", eval_start, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_tmo", timeout_flag, 0);
        rst = 1'b0;
        tick();

        // always accept, answer two cycles after eval_start
        set_tabs(0, 0);
        lat_fix = 2;
        model(8'd5, 32'd10);
        chk("pin_acc_frac", exp_frac, 16'h0202);
        chk("pin_acc_iter", 32'(exp_iter), 6);
        run_search(8'd4, 8'd5, 32'd10, 0);
        chk("acc_int_lit", cfg_int, 16'h0404);
        lat_fix = 0;

        // error equal to threshold accepts, one above rejects
        set_tabs(1, 0);
        model(8'd6, 32'd100);
        chk("pin_bnd_frac", exp_frac, 16'h0404);
        chk("pin_bnd_iter", 32'(exp_iter), 6);
        run_search(8'd4, 8'd6, 32'd100, 0);
        chk("bnd_frac_lit", cfg_frac, 16'h0404);

        // silent evaluator: every trial times out
        set_tabs(0, 1);
        model(8'd5, 32'd10);
        chk("pin_tmo_frac", exp_frac, 16'h0505);
        chk("pin_tmo_iter", 32'(exp_iter), 2);
        chk("pin_tmo_flag", 32'(exp_tmo), 1);
        run_search(8'd4, 8'd5, 32'd10, 0);
        chk("tmo_flag_lit", timeout_flag, 1);

        // next search clears the sticky flag
        set_tabs(0, 0);
        run_search(8'd3, 8'd4, 32'd5, 0);
        chk("tmo_cleared", timeout_flag, 0);

        // abort during the first evaluation, then a late answer
        set_tabs(0, 1);
        model(8'd8, 32'd10);
        exp_int = {8'd4, 8'd4};
        init_int = 8'd4; init_frac = 8'd8; err_thresh = 32'd10;
        d0 = done_cnt;
        mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (eval_start !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        chk("abort_saw_eval", eval_start, 1);
        abort  = 1'b1;
        mon_en = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_frac", cfg_frac, 16'h0808);
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("abort_iter", iter_cnt, 0);
        late_req++;
        repeat (6) tick();
        chk("late_frac", cfg_frac, 16'h0808);
        chk("late_busy", busy, 0);
        chk("late_iter", iter_cnt, 0);

        // randomized searches, one with a stray start mid-run
        for (int r = 0; r < 10; r++) begin
            set_tabs(2, 2);
            run_search(8'($urandom_range(20, 1)), 8'($urandom_range(20, 0)),
                       32'($urandom_range(90, 10)), (r == 3) ? 7 : 0);
        end

        // reset in the middle of an evaluation
        set_tabs(2, 0);
        model(8'd9, 32'd60);
        exp_int = {8'd5, 8'd5};
        init_int = 8'd5; init_frac = 8'd9; err_thresh = 32'd60;
        lat_fix = 5;
        mon_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (eval_start !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        chk("rst_saw_eval", eval_start, 1);
        tick();
        rst    = 1'b1;
        mon_en = 1'b0;
        tick();
        chk("mid_rst_cfg_int", cfg_int, 16'h1010);
        chk("mid_rst_cfg_frac", cfg_frac, 16'h1010);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_eval_start", eval_start, 0);
        chk("mid_rst_iter", iter_cnt, 0);
        chk("mid_rst_tmo", timeout_flag, 0);
        rst = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wlo_search_ctrl.md
Name: wlo_search_ctrl

Overview:
- Greedy word-length search sequencer for a bank of NUM_VAR bit-switch (int/frac truncation) stages.
- Drives per-variable num_int/num_frac configuration buses.
- Sequences one evaluation per trial through a start/done handshake with an external error evaluator.
- Per variable, shrinks fractional bits one at a time while the evaluated error stays within threshold; otherwise restores the last good value and moves on.

Parameters:
- NUM_VAR, 4, number of variables (bit-switch instances) configured
- MAX_LEN, 32, datapath word length of each bit switch
- INT_POS, 16, index of the integer/fraction boundary (max fractional bits)
- MIN_FRAC, 0, lower bound on num_frac during the search
- ERR_W, 32, width of error metric and threshold (unsigned)
- TIMEOUT, 1024, max cycles to wait for eval_done per trial

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle search request, honoured only in IDLE
- abort  in  1  terminate search, honoured in any busy state
- init_int  in  8  num_int loaded into every variable at start
- init_frac  in  8  num_frac loaded into every variable at start; clamped to INT_POS
- err_thresh  in  ERR_W  acceptance threshold, sampled at start
- eval_start  out  1  one-cycle pulse: configuration stable, evaluate it
- eval_done  in  1  evaluator completion strobe
- eval_err  in  ERR_W  error metric, valid when eval_done=1
- cfg_int  out  NUM_VAR*8  per-variable num_int, variable v at bits [8v+7:8v]
- cfg_frac  out  NUM_VAR*8  per-variable num_frac, same packing
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- iter_cnt  out  16  evaluations performed this search, saturating at 16'hFFFF
- timeout_flag  out  1  sticky; set if any trial timed out; cleared at start

Behaviour:
- Reset values:
  - every cfg_int = MAX_LEN-INT_POS; every cfg_frac = INT_POS (full-precision pass-through)
  - busy, done, eval_start, timeout_flag = 0; iter_cnt = 0
  - state = IDLE
- All outputs are registered.
- States: IDLE, INIT, TRY, EVAL, DECIDE, NEXT, DONE.
- IDLE:
  - start=1 -> INIT.
  - busy rises the cycle after start.
- INIT, one cycle:
  - load all cfg_int=init_int and all cfg_frac=min(init_frac, INT_POS).
  - var index v=0; iter_cnt=0; timeout_flag=0; latch err_thresh.
  - -> TRY.
- TRY:
  - cfg_frac[v] <= MIN_FRAC -> NEXT, no evaluation.
  - otherwise cfg_frac[v] -= 1 -> EVAL.
- EVAL:
  - eval_start=1 on the first EVAL cycle only; the timer starts at 0.
  - eval_done is sampled from the cycle after eval_start onward; capture eval_err and go to DECIDE.
  - Timer reaches TIMEOUT-1 without eval_done: set timeout_flag, mark the trial rejected, go to DECIDE.
  - cfg buses are held constant throughout EVAL.
- DECIDE, one cycle:
  - iter_cnt += 1 (saturating).
  - Accept when not timed out and eval_err <= latched threshold (equality accepts) -> TRY, same v.
  - Reject: cfg_frac[v] += 1 (restore) -> NEXT.
- NEXT:
  - v==NUM_VAR-1 -> DONE.
  - otherwise v+=1 -> TRY.
- DONE:
  - done=1 for exactly one cycle, then IDLE; busy is 0 in that IDLE cycle.
  - cfg buses retain final values until the next start or reset.
- abort:
  - If abort=1 in EVAL or DECIDE, restore the pending trial (cfg_frac[v] += 1).
  - In any busy state, go to IDLE the next cycle with no done pulse and no eval_start.
  - Abort outranks all other transitions that cycle.
- Ignored inputs:
  - eval_done outside EVAL is ignored, including a late response after abort or timeout.
  - start while busy is ignored.
- cfg_int is never changed by the search; only cfg_frac is searched.
- rst mid-search returns to reset values the next cycle, regardless of state.

Test Plan:
- Reset: assert rst 2 cycles -> cfg_int lanes=16, cfg_frac lanes=16, busy=done=eval_start=0, iter_cnt=0.
- Always-accept, NUM_VAR=2, MIN_FRAC=2, init_int=4, init_frac=5, thresh=10, evaluator returns err=0 two cycles after eval_start:
  - each variable steps 5->4->3->2 and stops without evaluating at 2.
  - final cfg_frac=2,2; cfg_int=4,4; iter_cnt=6; exactly one done pulse; eval_start pulsed 6 times.
- Threshold boundary, init_frac=6, thresh=100:
  - evaluator returns 100 for frac>=4, 101 for frac=3.
  - each variable accepts 5 and 4 (err==thresh), rejects 3 and restores to 4.
  - final cfg_frac=4,4; iter_cnt=6.
- Timeout, TIMEOUT=64, evaluator silent, init_frac=5:
  - each trial rejected after 64 EVAL cycles, timeout_flag=1, final cfg_frac=5,5, iter_cnt=2, done pulses.
  - A later start clears timeout_flag.
- abort and late responses:
  - abort during the first EVAL of variable 0 (init_frac=8) -> next cycle IDLE, busy=0, cfg_frac[0]=8, no done.
  - An eval_done delivered 3 cycles later leaves state and cfg unchanged.
- start during busy and reset mid-search:
  - a second start pulse while busy has no effect on v or iter_cnt.
  - rst asserted mid-EVAL -> all outputs at reset values the following cycle.
